// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use hazard detection and taken-branch flush control for a
// five-stage pipeline. It drives PC/IF-ID hold, the IF/ID bubble and the
// ID/EX flush, and keeps saturating counters of stall cycles and branch
// flushes.
module hazard_ctrl #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_rs1_used,
    input  logic             ifid_rs2_used,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rd,
    input  logic             branch_taken,
    input  logic             cnt_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int REM_W = $clog2(LOAD_STALL + 1);

    typedef enum logic {RUN, LU_STALL} state_t;

    state_t             state_reg;
    logic [REM_W-1:0]   rem_reg;
    logic               hazard;
    logic               stall_now;
    logic [1:0]         cnt_inc;
    logic [CNT_W-1:0]   cnt_reg [2];

    // A load in EX whose destination (never x0) is read by the instruction in ID.
    assign hazard = idex_memread && (idex_rd != 5'd0) &&
                    ((ifid_rs1_used && (idex_rd == ifid_rs1)) ||
                     (ifid_rs2_used && (idex_rd == ifid_rs2)));

    // Once in LU_STALL the stall runs to completion without re-checking the
    // hazard; a taken branch always wins because the stalled instruction is
    // on the wrong path.
    assign stall_now = !branch_taken && ((state_reg == LU_STALL) || hazard);

    // Mealy pipeline controls; reset forces the bubble/hold pattern at once.
    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (stall_now) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Stall sequencer: rem counts the bubbles still owed after the first one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            rem_reg   <= '0;
        end else if (branch_taken) begin
            state_reg <= RUN;
            rem_reg   <= '0;
        end else if (state_reg == LU_STALL) begin
            rem_reg <= rem_reg - REM_W'(1);
            if (rem_reg == REM_W'(1)) begin
                state_reg <= RUN;
            end
        end else if (hazard && (LOAD_STALL > 1)) begin
            state_reg <= LU_STALL;
            rem_reg   <= REM_W'(LOAD_STALL - 1);
        end
    end

    assign cnt_inc[0] = stall_now;
    assign cnt_inc[1] = branch_taken;

    // Saturating performance counters: 0 = stall cycles, 1 = branch flushes.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_clr) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
                    cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign stall_count = cnt_reg[0];
    assign flush_count = cnt_reg[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: three instances (LOAD_STALL=1, LOAD_STALL=3,
// CNT_W=4) each with their own stimulus, a vector table for single-cycle
// behaviour and hand-written sequences for multi-cycle stalls, branch aborts,
// reset mid-stall and counter saturation.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic       clr;
    } in_t;

    // o = {pc_write, ifid_write, ifid_flush, idex_flush}
    typedef struct {
        in_t        in;
        logic [3:0] o;
        int         sc;
        int         fc;
    } vec_t;

    logic        clk;
    logic        rst_a, rst_b, rst_c;
    in_t         in_a, in_b, in_c;
    logic [3:0]  o_a, o_b, o_c;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    vec_t vecs [12];

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .reset(rst_a),
        .ifid_rs1(in_a.rs1), .ifid_rs2(in_a.rs2),
        .ifid_rs1_used(in_a.u1), .ifid_rs2_used(in_a.u2),
        .idex_memread(in_a.mr), .idex_rd(in_a.rd),
        .branch_taken(in_a.br), .cnt_clr(in_a.clr),
        .pc_write(o_a[3]), .ifid_write(o_a[2]),
        .ifid_flush(o_a[1]), .idex_flush(o_a[0]),
        .stall_count(sc_a), .flush_count(fc_a)
    );

    hazard_ctrl #(.LOAD_STALL(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset(rst_b),
        .ifid_rs1(in_b.rs1), .ifid_rs2(in_b.rs2),
        .ifid_rs1_used(in_b.u1), .ifid_rs2_used(in_b.u2),
        .idex_memread(in_b.mr), .idex_rd(in_b.rd),
        .branch_taken(in_b.br), .cnt_clr(in_b.clr),
        .pc_write(o_b[3]), .ifid_write(o_b[2]),
        .ifid_flush(o_b[1]), .idex_flush(o_b[0]),
        .stall_count(sc_b), .flush_count(fc_b)
    );

    hazard_ctrl #(.LOAD_STALL(1), .CNT_W(4)) dut_c (
        .clk(clk), .reset(rst_c),
        .ifid_rs1(in_c.rs1), .ifid_rs2(in_c.rs2),
        .ifid_rs1_used(in_c.u1), .ifid_rs2_used(in_c.u2),
        .idex_memread(in_c.mr), .idex_rd(in_c.rd),
        .branch_taken(in_c.br), .cnt_clr(in_c.clr),
        .pc_write(o_c[3]), .ifid_write(o_c[2]),
        .ifid_flush(o_c[1]), .idex_flush(o_c[0]),
        .stall_count(sc_c), .flush_count(fc_c)
    );

    always #5 clk = ~clk;

    function automatic in_t mk(int rs1, int rs2, bit u1, bit u2, bit mr, int rd, bit br, bit clr);
        in_t v;
        v.rs1 = 5'(rs1);
        v.rs2 = 5'(rs2);
        v.u1  = u1;
        v.u2  = u2;
        v.mr  = mr;
        v.rd  = 5'(rd);
        v.br  = br;
        v.clr = clr;
        return v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        in_t hz, idle, br_only;
        hz      = mk(5, 0, 1, 0, 1, 5, 0, 0);
        idle    = mk(0, 0, 0, 0, 0, 0, 0, 0);
        br_only = mk(0, 0, 0, 0, 0, 0, 1, 0);

        // Single-cycle vectors for LOAD_STALL=1; counts are after the clock edge.
        vecs[0]  = '{idle,                        4'b1100, 0, 0};
        vecs[1]  = '{hz,                          4'b0001, 1, 0};
        vecs[2]  = '{idle,                        4'b1100, 1, 0};
        vecs[3]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0), 4'b1100, 1, 0};
        vecs[4]  = '{mk(3, 7, 1, 0, 1, 7, 0, 0), 4'b1100, 1, 0};
        vecs[5]  = '{mk(3, 7, 1, 1, 1, 7, 0, 0), 4'b0001, 2, 0};
        vecs[6]  = '{mk(5, 0, 1, 0, 1, 5, 1, 0), 4'b1111, 2, 1};
        vecs[7]  = '{br_only,                     4'b1111, 2, 2};
        vecs[8]  = '{mk(5, 0, 1, 0, 1, 5, 0, 1), 4'b0001, 0, 0};
        vecs[9]  = '{mk(5, 0, 1, 0, 0, 5, 0, 0), 4'b1100, 0, 0};
        vecs[10] = '{mk(5, 0, 0, 0, 1, 5, 0, 0), 4'b1100, 0, 0};
        vecs[11] = '{mk(9, 9, 1, 1, 1, 9, 0, 0), 4'b0001, 1, 0};

        clk   = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        in_a  = idle;
        in_b  = idle;
        in_c  = idle;

        // Reset values while reset is held across clock edges.
        #22;
        chk("rst_a_outs", int'(o_a), 4'b0011);
        chk("rst_b_outs", int'(o_b), 4'b0011);
        chk("rst_a_stall_cnt", int'(sc_a), 0);
        chk("rst_a_flush_cnt", int'(fc_a), 0);
        chk("rst_c_stall_cnt", int'(sc_c), 0);
        $display("reset: outs_a=%b sc_a=%0d fc_a=%0d", o_a, sc_a, fc_a);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Table-driven single-cycle checks on the LOAD_STALL=1 instance.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_a = vecs[i].in;
            #1;
            chk($sformatf("vec%0d_outs", i), int'(o_a), int'(vecs[i].o));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stall_cnt", i), int'(sc_a), vecs[i].sc);
            chk($sformatf("vec%0d_flush_cnt", i), int'(fc_a), vecs[i].fc);
            $display("vec%0d: outs=%b sc=%0d fc=%0d", i, o_a, sc_a, fc_a);
        end

        // LOAD_STALL=3: one hazard gives exactly three stall cycles.
        @(negedge clk);
        in_b = hz;
        #1 chk("b_stall1_outs", int'(o_b), 4'b0001);
        @(negedge clk);
        in_b = idle;
        #1 chk("b_stall2_outs", int'(o_b), 4'b0001);
        @(negedge clk);
        #1 chk("b_stall3_outs", int'(o_b), 4'b0001);
        chk("b_stall3_cnt", int'(sc_b), 2);
        @(negedge clk);
        #1 chk("b_run4_outs", int'(o_b), 4'b1100);
        chk("b_run4_cnt", int'(sc_b), 3);
        $display("b multi-stall: outs=%b sc=%0d", o_b, sc_b);

        // LOAD_STALL=3: taken branch in the second stall cycle aborts it.
        @(negedge clk);
        in_b = mk(0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        chk("b_clr_cnt", int'(sc_b), 0);
        in_b = hz;
        #1 chk("b_abort_stall1_outs", int'(o_b), 4'b0001);
        @(negedge clk);
        in_b = br_only;
        #1 chk("b_abort_branch_outs", int'(o_b), 4'b1111);
        @(posedge clk);
        #1 chk("b_abort_stall_cnt", int'(sc_b), 1);
        chk("b_abort_flush_cnt", int'(fc_b), 1);
        @(negedge clk);
        in_b = idle;
        #1 chk("b_abort_run_outs", int'(o_b), 4'b1100);
        $display("b branch abort: outs=%b sc=%0d fc=%0d", o_b, sc_b, fc_b);

        // LOAD_STALL=3: reset in the middle of a stall.
        @(negedge clk);
        in_b = hz;
        @(negedge clk);
        in_b = idle;
        #1 chk("b_midstall_outs", int'(o_b), 4'b0001);
        #1 rst_b = 1'b1;
        #1 chk("b_midrst_outs", int'(o_b), 4'b0011);
        chk("b_midrst_stall_cnt", int'(sc_b), 0);
        chk("b_midrst_flush_cnt", int'(fc_b), 0);
        @(negedge clk);
        rst_b = 1'b0;
        #1 chk("b_after_rst_outs", int'(o_b), 4'b1100);
        @(posedge clk);
        #1 chk("b_after_rst_cnt", int'(sc_b), 0);
        $display("b reset mid-stall: outs=%b sc=%0d", o_b, sc_b);

        // CNT_W=4: stall counter saturates at 15.
        @(negedge clk);
        in_c = hz;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1 chk($sformatf("c_sat_stall_%0d", k), int'(sc_c), (k > 15) ? 15 : k);
        end
        $display("c stall saturation: sc=%0d", sc_c);
        @(negedge clk);
        in_c = mk(5, 0, 1, 0, 1, 5, 0, 1);
        #1 chk("c_clr_hz_outs", int'(o_c), 4'b0001);
        @(posedge clk);
        #1 chk("c_clr_hz_cnt", int'(sc_c), 0);
        $display("c clear with hazard: sc=%0d", sc_c);

        // CNT_W=4: flush counter saturates at 15.
        @(negedge clk);
        in_c = br_only;
        repeat (17) @(posedge clk);
        #1 chk("c_sat_flush", int'(fc_c), 15);
        chk("c_sat_flush_stall", int'(sc_c), 0);
        $display("c flush saturation: fc=%0d", fc_c);
        @(negedge clk);
        in_c = idle;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
